// File: rtl/event_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : event_scheduler_if
//  Description : Command bus for the event scheduler. The producer drives a
//                {channel, delay} command with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface event_scheduler_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_chan;
  logic [DW-1:0] cmd_delay;

  modport master (output cmd_valid, cmd_chan, cmd_delay, input cmd_ready);
  modport slave  (input cmd_valid, cmd_chan, cmd_delay, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : event_scheduler
//  Description : Queues {channel, delay} commands in a small FIFO, waits the
//                programmed number of cycles per command, then drives a
//                one-cycle trigger pulse on the selected channel and keeps
//                per-channel fired-event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_scheduler #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    flush,
  event_scheduler_if.slave             cmd,
  output logic [1:0]                   trig,
  output logic [CW-1:0]                evt_cnt0,
  output logic [CW-1:0]                evt_cnt1,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_nempty;
  logic              w_clear;

  logic              r_mem_chan  [DEPTH];
  logic [DW-1:0]     r_mem_delay [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_LW-1:0]   r_level;

  logic [DW-1:0]     r_dcnt;
  logic              r_chan;
  logic [1:0]        r_trig;
  logic [CW-1:0]     r_cnt0;
  logic [CW-1:0]     r_cnt1;

  // Reset and flush both discard queued and in-flight work.
  assign w_clear  = !rst_n || flush;
  // Full is judged on the registered level only, so a same-edge pop never
  // opens a slot for a push.
  assign w_full   = (r_level == c_LW'(DEPTH));
  assign w_nempty = (r_level != '0);
  assign w_push   = cmd.cmd_valid && !w_full;

  // Sequencer next-state and pop decision.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_dcnt == '0) begin
          w_state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage; contents need no reset because pointers gate validity.
  always_ff @(posedge clk) begin
    if (!w_clear && w_push) begin
      r_mem_chan[r_wr_ptr]  <= cmd.cmd_chan;
      r_mem_delay[r_wr_ptr] <= cmd.cmd_delay;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Load the popped command, then count its delay down while waiting.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_dcnt <= '0;
      r_chan <= 1'b0;
    end else if (w_pop) begin
      r_dcnt <= r_mem_delay[r_rd_ptr];
      r_chan <= r_mem_chan[r_rd_ptr];
    end else if (r_state == WAIT && r_dcnt != '0) begin
      r_dcnt <= r_dcnt - DW'(1);
    end
  end

  // Registered trigger: raised on the edge that enters FIRE, low otherwise.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_trig <= 2'b00;
    end else if (r_state == WAIT && r_dcnt == '0) begin
      r_trig <= r_chan ? 2'b10 : 2'b01;
    end else begin
      r_trig <= 2'b00;
    end
  end

  // Event counters bump at the end of FIRE; flush keeps them, reset clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (r_state == FIRE) begin
      if (r_chan) begin
        r_cnt1 <= r_cnt1 + CW'(1);
      end else begin
        r_cnt0 <= r_cnt0 + CW'(1);
      end
    end
  end

  assign cmd.cmd_ready = !w_full;
  assign trig          = r_trig;
  assign evt_cnt0      = r_cnt0;
  assign evt_cnt1      = r_cnt1;
  assign level         = r_level;
  assign busy          = (r_state != IDLE) || w_nempty;

endmodule
`default_nettype wire

// File: tb/tb_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_scheduler
//  Description : Self-checking bench for event_scheduler: directed vector
//                table, hand-written corner sequences and randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_scheduler;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [1:0]             trig;
  logic [CW-1:0]          evt_cnt0;
  logic [CW-1:0]          evt_cnt1;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;

  event_scheduler_if #(.DW(DW)) cmd_if ();

  event_scheduler #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .cmd      (cmd_if),
    .trig     (trig),
    .evt_cnt0 (evt_cnt0),
    .evt_cnt1 (evt_cnt1),
    .level    (level),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending commands plus the absolute edge number
  // at which the in-flight command's pulse starts.
  typedef struct { bit chan; int delay; } cmd_t;
  cmd_t q[$];
  bit   m_act;
  bit   m_chan;
  int   m_fire;
  int   m_cnt0;
  int   m_cnt1;
  bit   m_pushed;
  int   n = 0;

  int         pulse_n[$];
  logic [1:0] pulse_v[$];

  typedef struct {
    bit rst_n; bit flush; bit valid; bit chan; int delay;
    logic [1:0] trig; int level; bit busy; bit ready; int cnt0; int cnt1;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic addv(input bit r, input bit f, input bit v, input bit c, input int d,
                      input logic [1:0] t, input int l, input bit b, input bit rdy,
                      input int c0, input int c1);
    vec_t x;
    x.rst_n = r; x.flush = f; x.valid = v; x.chan = c; x.delay = d;
    x.trig = t; x.level = l; x.busy = b; x.ready = rdy; x.cnt0 = c0; x.cnt1 = c1;
    vecs.push_back(x);
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input bit c, input int d);
    rst_n            = r;
    flush            = f;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_chan  = c;
    cmd_if.cmd_delay = DW'(d);
  endtask

  task automatic model_step();
    int   sz;
    cmd_t c;
    m_pushed = 1'b0;
    if (!rst_n) begin
      q.delete(); m_act = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      return;
    end
    sz = q.size();
    if (m_act && n == m_fire + 1) begin
      if (m_chan) m_cnt1++; else m_cnt0++;
      m_act = 1'b0;
    end
    if (flush) begin
      q.delete(); m_act = 1'b0;
      return;
    end
    if (!m_act && sz != 0) begin
      c      = q.pop_front();
      m_act  = 1'b1;
      m_chan = c.chan;
      m_fire = n + c.delay + 1;
    end
    if (cmd_if.cmd_valid && sz < DEPTH) begin
      c.chan  = cmd_if.cmd_chan;
      c.delay = int'(cmd_if.cmd_delay);
      q.push_back(c);
      m_pushed = 1'b1;
    end
  endtask

  task automatic check_model();
    logic [1:0] et;
    et = (m_act && m_fire == n) ? (m_chan ? 2'b10 : 2'b01) : 2'b00;
    chk("model.trig",  32'(trig), 32'(et));
    chk("model.level", 32'(level), 32'(q.size()));
    chk("model.busy",  32'(busy), 32'(m_act || q.size() != 0));
    chk("model.ready", 32'(cmd_if.cmd_ready), 32'(q.size() < DEPTH));
    chk("model.cnt0",  32'(evt_cnt0), 32'(m_cnt0 % (1 << CW)));
    chk("model.cnt1",  32'(evt_cnt1), 32'(m_cnt1 % (1 << CW)));
  endtask

  task automatic cycle();
    @(posedge clk);
    n++;
    model_step();
    @(negedge clk);
    check_model();
    if (trig !== 2'b00) begin
      pulse_n.push_back(n);
      pulse_v.push_back(trig);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    drive(1, 0, 0, 0, 0);
    while ((m_act || q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, ".idle_timeout"}, 32'(m_act || q.size() != 0), 32'd0);
  endtask

  initial begin
    int         p;
    bit         saw_full;
    bit         accepted;
    int         sent;
    logic [1:0] exp_order [6];

    drive(0, 0, 0, 0, 0);

    // Single command {0,3}: pulse five edges after the push, then idle.
    addv(0,0,0,0,0, 2'b00,0,0,1,0,0);
    addv(1,0,0,0,0, 2'b00,0,0,1,0,0);
    addv(1,0,1,0,3, 2'b00,1,1,1,0,0);
    for (int i = 0; i < 4; i++) addv(1,0,0,0,0, 2'b00,0,1,1,0,0);
    addv(1,0,0,0,0, 2'b01,0,1,1,0,0);
    addv(1,0,0,0,0, 2'b00,0,0,1,1,0);
    // Four back-to-back commands after a reset: spacing 2, 4, 3.
    addv(0,0,0,0,0, 2'b00,0,0,1,0,0);
    addv(1,0,1,0,0, 2'b00,1,1,1,0,0);
    addv(1,0,1,1,0, 2'b00,1,1,1,0,0);
    addv(1,0,1,0,2, 2'b01,2,1,1,0,0);
    addv(1,0,1,1,1, 2'b00,2,1,1,1,0);
    addv(1,0,0,0,0, 2'b10,2,1,1,1,0);
    addv(1,0,0,0,0, 2'b00,1,1,1,1,1);
    addv(1,0,0,0,0, 2'b00,1,1,1,1,1);
    addv(1,0,0,0,0, 2'b00,1,1,1,1,1);
    addv(1,0,0,0,0, 2'b01,1,1,1,1,1);
    addv(1,0,0,0,0, 2'b00,0,1,1,2,1);
    addv(1,0,0,0,0, 2'b00,0,1,1,2,1);
    addv(1,0,0,0,0, 2'b10,0,1,1,2,1);
    addv(1,0,0,0,0, 2'b00,0,0,1,2,2);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].valid, vecs[i].chan, vecs[i].delay);
      cycle();
      chk($sformatf("vec%0d.trig", i),  32'(trig),             32'(vecs[i].trig));
      chk($sformatf("vec%0d.level", i), 32'(level),            32'(vecs[i].level));
      chk($sformatf("vec%0d.busy", i),  32'(busy),             32'(vecs[i].busy));
      chk($sformatf("vec%0d.ready", i), 32'(cmd_if.cmd_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d.cnt0", i),  32'(evt_cnt0),         32'(vecs[i].cnt0));
      chk($sformatf("vec%0d.cnt1", i),  32'(evt_cnt1),         32'(vecs[i].cnt1));
    end

    // Fill the FIFO behind a long command and hold a fifth one at full.
    drive(0, 0, 0, 0, 0); cycle();
    pulse_n.delete(); pulse_v.delete();
    drive(1, 0, 1, 0, 10); cycle();
    drive(1, 0, 1, 1, 0);  cycle();
    drive(1, 0, 1, 0, 1);  cycle();
    drive(1, 0, 1, 1, 2);  cycle();
    drive(1, 0, 1, 0, 0);  cycle();
    saw_full = 1'b0;
    accepted = 1'b0;
    drive(1, 0, 1, 1, 3);
    for (int k = 0; k < 100 && !accepted; k++) begin
      if (cmd_if.cmd_ready === 1'b0) saw_full = 1'b1;
      cycle();
      accepted = m_pushed;
    end
    chk("full.ready_low_seen", 32'(saw_full), 32'd1);
    chk("full.fifth_accepted", 32'(accepted), 32'd1);
    wait_idle("full", 200);
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
    exp_order[3] = 2'b10; exp_order[4] = 2'b01; exp_order[5] = 2'b10;
    chk("full.pulse_count", 32'(pulse_v.size()), 32'd6);
    for (int i = 0; i < 6 && i < pulse_v.size(); i++)
      chk($sformatf("full.pulse%0d", i), 32'(pulse_v[i]), 32'(exp_order[i]));
    chk("full.cnt0", 32'(evt_cnt0), 32'd3);
    chk("full.cnt1", 32'(evt_cnt1), 32'd3);

    // Flush mid-WAIT of a long command: no pulse, counters held.
    pulse_n.delete(); pulse_v.delete();
    drive(1, 0, 1, 1, 200); cycle();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 51; k++) cycle();
    drive(1, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 260; k++) cycle();
    chk("flush.no_pulse", 32'(pulse_v.size()), 32'd0);
    chk("flush.level",    32'(level), 32'd0);
    chk("flush.busy",     32'(busy),  32'd0);
    chk("flush.cnt1",     32'(evt_cnt1), 32'd3);

    // Reset mid-WAIT, then a short command fires exactly three edges later.
    pulse_n.delete(); pulse_v.delete();
    drive(1, 0, 1, 0, 100); cycle();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 21; k++) cycle();
    drive(0, 0, 0, 0, 0); cycle();
    drive(1, 0, 1, 0, 1); cycle();
    p = n;
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cycle();
    chk("rstmid.pulse_count", 32'(pulse_n.size()), 32'd1);
    if (pulse_n.size() > 0) chk("rstmid.pulse_edge", 32'(pulse_n[0]), 32'(p + 3));
    chk("rstmid.cnt0", 32'(evt_cnt0), 32'd1);

    // Seventeen channel-0 events wrap the 4-bit counter to 1.
    drive(0, 0, 0, 0, 0); cycle();
    pulse_n.delete(); pulse_v.delete();
    sent = 0;
    for (int k = 0; k < 2000 && sent < 17; k++) begin
      drive(1, 0, 1, 0, $urandom_range(0, 3));
      cycle();
      if (m_pushed) sent++;
    end
    wait_idle("wrap", 400);
    chk("wrap.pulses", 32'(pulse_v.size()), 32'd17);
    chk("wrap.cnt0",   32'(evt_cnt0), 32'd1);
    chk("wrap.cnt1",   32'(evt_cnt1), 32'd0);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 2) != 0,
            1'($urandom),
            ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
      cycle();
    end
    wait_idle("rand", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
